ofmap_collector: RTL and testbench

OFMAP_COLLECTOR -- requirements
Module: ofmap_collector

---
 rtl/ofmap_collector.sv | 140 ++++++++++++++
 tb/tb_ofmap_collector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_collector.sv
// Packs 16-bit convolution results into 32-bit words and streams them to memory
// through a small FIFO. Odd-length runs are padded with a zero upper half.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_COLLECT | accepting din beats, packing pairs into the FIFO
// S_FLUSH   | stream ended; push any half word and drain the FIFO
// S_DONE    | one-cycle completion pulse
module ofmap_collector #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] base_addr_i,
    input  logic [15:0] din_i,
    input  logic        din_valid_i,
    input  logic        conv_done_i,
    input  logic        wr_ready_i,
    output logic        wr_valid_o,
    output logic [15:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] ofmap_count_o,
    output logic        overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0] base_q, base_d, idx_q, idx_d, count_q, count_d, lo_q, lo_d;
    logic        half_q, half_d, ovf_q, ovf_d;
    logic        fifo_empty, fifo_full, pop, push_room, push_req, push_ok;
    logic [31:0] push_word;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && wr_ready_i;
    assign push_room  = !fifo_full || pop;
    assign push_ok    = push_req && push_room;

    assign wr_ptr_d = push_ok ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    assign rd_ptr_d = pop     ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx_d     = pop ? idx_q + 16'd1 : idx_q;
        count_d   = count_q;
        lo_d      = lo_q;
        half_d    = half_q;
        ovf_d     = ovf_q;
        push_req  = 1'b0;
        push_word = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COLLECT;
                    base_d  = base_addr_i;
                    idx_d   = 16'd0;
                    count_d = 16'd0;
                    half_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_COLLECT: begin
                if (din_valid_i) begin
                    count_d = count_q + 16'd1;
                    if (!half_q) begin
                        lo_d   = din_i;
                        half_d = 1'b1;
                    end else begin
                        push_req  = 1'b1;
                        push_word = {din_i, lo_q};
                        half_d    = 1'b0;
                        if (!push_room) ovf_d = 1'b1;
                    end
                end
                if (conv_done_i) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // A pending half retries every cycle until the FIFO has room.
                if (half_q) begin
                    push_req  = 1'b1;
                    push_word = {16'h0000, lo_q};
                    if (push_room) half_d = 1'b0;
                end else if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            base_q   <= 16'h0;
            idx_q    <= 16'h0;
            count_q  <= 16'h0;
            lo_q     <= 16'h0;
            half_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            lo_q     <= lo_d;
            half_q   <= half_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

    // Storage is not reset, so the data bus is gated to zero while empty.
    assign wr_valid_o    = !fifo_empty;
    assign wr_data_o     = fifo_empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign wr_addr_o     = base_q + idx_q;
    assign busy_o        = (state_q == S_COLLECT) || (state_q == S_FLUSH);
    assign done_o        = (state_q == S_DONE);
    assign ofmap_count_o = count_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_ofmap_collector.sv
// Randomized and directed bench for ofmap_collector against a queue-based
// behavioural model of the packing, buffering and write-out rules.
module tb_ofmap_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, start, din_valid, conv_done, wr_ready;
    logic [15:0] base_addr, din;
    logic        wr_valid, busy, done, overflow;
    logic [15:0] wr_addr, ofmap_count;
    logic [31:0] wr_data;

    ofmap_collector #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .din_i(din), .din_valid_i(din_valid), .conv_done_i(conv_done),
        .wr_ready_i(wr_ready), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .busy_o(busy), .done_o(done),
        .ofmap_count_o(ofmap_count), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase 0 idle, 1 collecting, 2 flushing, 3 completion cycle.
    logic [31:0] mq[$];
    int          m_phase;
    logic [15:0] m_base, m_idx, m_cnt, m_lo;
    bit          m_half, m_ovf;

    logic [31:0] log_data[$];
    logic [15:0] log_addr[$];
    int          done_pulses;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [15:0] prev_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_addr.delete();
        done_pulses = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b1; din_valid = 1'b1; conv_done = 1'b1;
        din = 16'h1234; base_addr = 16'h4321; wr_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        m_phase = 0; m_base = 0; m_idx = 0; m_cnt = 0; m_lo = 0;
        m_half = 0; m_ovf = 0; prev_stall = 0;
        check_eq("rst_wr_valid", wr_valid, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_count", ofmap_count, 0);
        check_eq("rst_overflow", overflow, 0);
    endtask

    task automatic step(input bit st, input logic [15:0] ba, input bit dv,
                        input logic [15:0] d, input bit cd, input bit rdy);
        int          sz;
        bit          pop, room, req;
        logic [31:0] w;
        logic [15:0] exp_addr;
        start = st; base_addr = ba; din_valid = dv; din = d; conv_done = cd; wr_ready = rdy;
        #1;
        sz = mq.size();
        exp_addr = m_base + m_idx;
        check_eq("wr_valid", wr_valid, sz != 0);
        if (sz != 0) begin
            check_eq("wr_data", wr_data, mq[0]);
            check_eq("wr_addr", wr_addr, exp_addr);
        end
        if (prev_stall) begin
            check_eq("stall_data", wr_data, prev_data);
            check_eq("stall_addr", wr_addr, prev_addr);
        end
        prev_stall = wr_valid && !rdy;
        prev_data  = wr_data;
        prev_addr  = wr_addr;
        if (wr_valid && rdy) begin
            log_data.push_back(wr_data);
            log_addr.push_back(wr_addr);
        end
        pop  = (sz != 0) && rdy;
        room = (sz < DEPTH) || pop;
        req  = 0;
        w    = 32'h0;
        case (m_phase)
            0: if (st) begin
                m_phase = 1; m_base = ba; m_idx = 0; m_cnt = 0; m_half = 0; m_ovf = 0;
            end
            1: begin
                if (dv) begin
                    m_cnt++;
                    if (!m_half) begin
                        m_lo = d; m_half = 1;
                    end else begin
                        req = 1; w = {d, m_lo}; m_half = 0;
                        if (!room) m_ovf = 1;
                    end
                end
                if (cd) m_phase = 2;
            end
            2: begin
                if (m_half) begin
                    req = 1; w = {16'h0000, m_lo};
                    if (room) m_half = 0;
                end else if (sz == 0) begin
                    m_phase = 3;
                end
            end
            default: m_phase = 0;
        endcase
        if (pop) begin
            void'(mq.pop_front());
            m_idx++;
        end
        if (req && room) mq.push_back(w);
        @(posedge clk); #1;
        check_eq("busy", busy, (m_phase == 1) || (m_phase == 2));
        check_eq("done", done, m_phase == 3);
        check_eq("count", ofmap_count, m_cnt);
        check_eq("overflow", overflow, m_ovf);
        if (done) done_pulses++;
    endtask

    task automatic run_to_idle(input int rdy_pct, input int max_cyc);
        int n = 0;
        while (m_phase != 0 && n < max_cyc) begin
            step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 1) == 1,
                 16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 99) < rdy_pct);
            n++;
        end
        check_eq("drain_finished", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a_prev;
        do_reset();

        // Basic even run
        clear_log();
        step(1, 16'h0100, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i), i == 4, 1);
        run_to_idle(100, 50);
        check_eq("even_words", log_data.size(), 2);
        check_eq("even_w0", log_data[0], 32'h0002_0001);
        check_eq("even_a0", log_addr[0], 16'h0100);
        check_eq("even_w1", log_data[1], 32'h0004_0003);
        check_eq("even_a1", log_addr[1], 16'h0101);
        check_eq("even_done", done_pulses, 1);
        check_eq("even_count", ofmap_count, 4);
        check_eq("even_ovf", overflow, 0);

        // Odd run padded with zero upper half
        clear_log();
        step(1, 16'h0200, 0, 0, 0, 1);
        step(0, 0, 1, 16'h00AA, 0, 1);
        step(0, 0, 1, 16'h00BB, 0, 1);
        step(0, 0, 1, 16'h00CC, 0, 1);
        step(0, 0, 0, 16'h0000, 1, 1);
        run_to_idle(100, 50);
        check_eq("odd_words", log_data.size(), 2);
        check_eq("odd_w0", log_data[0], 32'h00BB_00AA);
        check_eq("odd_w1", log_data[1], 32'h0000_00CC);
        check_eq("odd_count", ofmap_count, 3);

        // Stalled memory: pairs 5 and 6 dropped
        clear_log();
        step(1, 16'h0300, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) step(0, 0, 1, 16'(i), i == 12, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'hDEAD, 1, 0);
        check_eq("stall_ovf", overflow, 1);
        check_eq("stall_none_written", log_data.size(), 0);
        check_eq("stall_valid", wr_valid, 1);
        run_to_idle(100, 50);
        check_eq("stall_words", log_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_order", log_data[i], {16'(2 * i + 2), 16'(2 * i + 1)});
            check_eq("stall_addr_seq", log_addr[i], 16'(16'h0300 + i));
        end
        check_eq("stall_done", done_pulses, 1);
        check_eq("stall_count", ofmap_count, 12);

        // Full throughput never overflows
        clear_log();
        step(1, 16'h0A00, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 16'($urandom), i == 19, 1);
        run_to_idle(100, 50);
        check_eq("thru_ovf", overflow, 0);
        check_eq("thru_words", log_data.size(), 10);

        // Random ready, random beats, stray start/din in idle
        for (int r = 0; r < 6; r++) begin
            clear_log();
            for (int i = 0; i < 3; i++)
                step(0, 16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            step(1, 16'($urandom), 0, 0, 0, $urandom_range(0, 1) == 1);
            for (int i = 0; i < 30; i++)
                step($urandom_range(0, 4) == 0, 16'($urandom), $urandom_range(0, 9) < 7,
                     16'($urandom), 0, $urandom_range(0, 1) == 1);
            step(0, 0, $urandom_range(0, 1) == 1, 16'($urandom), 1, $urandom_range(0, 1) == 1);
            run_to_idle(50, 400);
            check_eq("rand_done", done_pulses, 1);
            for (int i = 1; i < log_addr.size(); i++) begin
                a_prev = log_addr[i-1] + 16'd1;
                check_eq("rand_consecutive", log_addr[i], a_prev);
            end
        end

        // Reset mid-collect with two words queued, then a clean run
        clear_log();
        step(1, 16'h0400, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(16'h10 + i), 0, 0);
        check_eq("pre_rst_valid", wr_valid, 1);
        do_reset();
        clear_log();
        step(1, 16'h0500, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(16'h20 + i), i == 4, 1);
        run_to_idle(100, 50);
        check_eq("post_rst_words", log_data.size(), 2);
        check_eq("post_rst_a0", log_addr[0], 16'h0500);
        check_eq("post_rst_w0", log_data[0], 32'h0022_0021);

        // Address wrap
        clear_log();
        step(1, 16'hFFFF, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i), i == 4, 1);
        run_to_idle(100, 50);
        check_eq("wrap_a0", log_addr[0], 16'hFFFF);
        check_eq("wrap_a1", log_addr[1], 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
